// File: rtl/weight_loader.sv
// Packs a byte-wide weight stream into 72-bit 3x3 kernel words and writes them to the kernel buffer.
// Optional running byte checksum is enabled by defining WEIGHT_CHECKSUM_EN.
module weight_loader #(
  parameter int DEPTH = 21,
  parameter int IDX_W = 7,
  parameter int BYTES = 9
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [IDX_W-1:0]     num_kernels,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [7:0]           in_data,
  output logic                 in_ready,
  output logic                 wr_en,
  output logic [IDX_W-1:0]     wr_index,
  output logic [8*BYTES-1:0]   wr_data,
  output logic                 busy,
  output logic                 done,
  output logic [15:0]          checksum
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] LOAD = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam int              BC_W      = $clog2(BYTES);
  localparam logic [BC_W-1:0] LAST_BYTE = BC_W'(BYTES - 1);
  localparam logic [IDX_W-1:0] MAX_KERN = IDX_W'(DEPTH);

  logic [1:0]         state;
  logic [1:0]         state_next;
  logic [IDX_W-1:0]   target;
  logic [IDX_W-1:0]   kern_cnt;
  logic [BC_W-1:0]    byte_cnt;
  logic [8*BYTES-1:0] pack;
  logic [8*BYTES-1:0] pack_next;
  logic               take;
  logic               start_load;
  logic               last_kernel;

  assign take        = in_valid && in_ready;
  assign start_load  = (state == IDLE) && start && (num_kernels != '0);
  assign last_kernel = (kern_cnt == target - 1'b1);
  assign busy        = (state == LOAD);
  assign done        = (state == DONE);

  always_comb begin
    pack_next = pack;
    pack_next[{byte_cnt, 3'b000} +: 8] = in_data;
  end

  // in_ready is only low inside LOAD during the final write cycle, which is the cue to finish.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start)
          state_next = (num_kernels == '0) ? DONE : LOAD;
      end
      LOAD: begin
        if (abort)
          state_next = IDLE;
        else if (!in_ready)
          state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      state <= IDLE;
    else
      state <= state_next;
  end

  // The ninth byte bypasses the pack register straight into wr_data so the next kernel can start packing
  // on the very next cycle; abort on that same handshake suppresses the write.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      target   <= '0;
      kern_cnt <= '0;
      byte_cnt <= '0;
      pack     <= '0;
      in_ready <= 1'b0;
      wr_en    <= 1'b0;
      wr_index <= '0;
      wr_data  <= '0;
    end else begin
      wr_en <= 1'b0;
      if (start_load) begin
        target   <= (num_kernels > MAX_KERN) ? MAX_KERN : num_kernels;
        kern_cnt <= '0;
        byte_cnt <= '0;
        pack     <= '0;
        in_ready <= 1'b1;
      end else if (state == LOAD) begin
        if (abort) begin
          in_ready <= 1'b0;
        end else if (take) begin
          if (byte_cnt == LAST_BYTE) begin
            byte_cnt <= '0;
            wr_en    <= 1'b1;
            wr_data  <= pack_next;
            wr_index <= kern_cnt;
            kern_cnt <= kern_cnt + 1'b1;
            if (last_kernel)
              in_ready <= 1'b0;
          end else begin
            byte_cnt <= byte_cnt + 1'b1;
            pack     <= pack_next;
          end
        end
      end
    end
  end

`ifdef WEIGHT_CHECKSUM_EN
  logic [15:0] sum;

  // Every handshaken byte counts, including one that coincides with abort.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      sum <= '0;
    else if (start_load)
      sum <= '0;
    else if ((state == LOAD) && take)
      sum <= sum + {8'h00, in_data};
  end

  assign checksum = sum;
`else
  assign checksum = '0;
`endif

endmodule

// File: tb/tb_weight_loader.sv
// Directed self-checking bench for weight_loader: single/full/clamped loads, zero count, abort and mid-load reset.
module tb_weight_loader;
  localparam int IDX_W = 7;

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic [IDX_W-1:0]  num_kernels;
  logic              abort;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              wr_en;
  logic [IDX_W-1:0]  wr_index;
  logic [71:0]       wr_data;
  logic              busy;
  logic              done;
  logic [15:0]       checksum;

  int n_checks = 0;
  int n_pass   = 0;
  int hs_cnt    = 0;
  int done_cnt  = 0;
  int ready_cnt = 0;
  int hs_base, done_base, ready_base, wr_base;
  logic [IDX_W-1:0] idx_log[$];
  logic [71:0]      data_log[$];
  logic [15:0]      sum_model;

  always #5 clk = ~clk;

  weight_loader dut (
    .clk(clk), .rst(rst), .start(start), .num_kernels(num_kernels), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready), .wr_en(wr_en),
    .wr_index(wr_index), .wr_data(wr_data), .busy(busy), .done(done), .checksum(checksum)
  );

  // Event log sampled mid-cycle, where inputs and registered outputs are both settled.
  always @(negedge clk) begin
    if (in_valid && in_ready) hs_cnt++;
    if (in_ready) ready_cnt++;
    if (done) done_cnt++;
    if (wr_en) begin
      idx_log.push_back(wr_index);
      data_log.push_back(wr_data);
    end
  end

  task automatic checkOutput(input string tag, input logic [71:0] got, input logic [71:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic logic [71:0] expWord(input logic [7:0] base, input int k);
    logic [71:0] w;
    w = '0;
    for (int j = 0; j < 9; j++) w[8*j +: 8] = base + 8'(9*k + j);
    return w;
  endfunction

  task automatic clearLog();
    hs_base    = hs_cnt;
    done_base  = done_cnt;
    ready_base = ready_cnt;
    wr_base    = idx_log.size();
  endtask

  task automatic applyStimulus(input logic [IDX_W-1:0] n);
    start = 1'b1;
    num_kernels = n;
    @(posedge clk); #1;
    start = 1'b0;
    if (n != '0) sum_model = '0;
  endtask

  task automatic sendByte(input logic [7:0] b);
    logic ok;
    int   guard;
    ok = 1'b0;
    guard = 0;
    in_valid = 1'b1;
    in_data = b;
    while (!ok && guard < 50) begin
      ok = in_ready;
      @(posedge clk); #1;
      guard++;
    end
    if (!ok) checkOutput("byte_timeout", 72'd0, 72'd1);
    else sum_model += {8'h00, b};
  endtask

  task automatic sendStream(input int n, input logic [7:0] base, input bit gaps);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 2)) begin
          @(posedge clk); #1;
        end
      end
      sendByte(base + 8'(i));
    end
    in_valid = 1'b0;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic checkWrites(input int n, input logic [7:0] base);
    checkOutput("wr_count", 72'(idx_log.size() - wr_base), 72'(n));
    for (int k = 0; k < n; k++) begin
      if (wr_base + k < idx_log.size()) begin
        checkOutput("wr_index", 72'(idx_log[wr_base + k]), 72'(k));
        checkOutput("wr_data", data_log[wr_base + k], expWord(base, k));
      end
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; start = 1'b0; num_kernels = '0; abort = 1'b0; in_valid = 1'b0; in_data = '0;
    sum_model = '0;
    @(posedge clk); #1;
    checkOutput("rst_in_ready", 72'(in_ready), 72'd0);
    checkOutput("rst_wr_en", 72'(wr_en), 72'd0);
    checkOutput("rst_wr_index", 72'(wr_index), 72'd0);
    checkOutput("rst_wr_data", wr_data, 72'd0);
    checkOutput("rst_busy", 72'(busy), 72'd0);
    checkOutput("rst_done", 72'(done), 72'd0);
    checkOutput("rst_checksum", 72'(checksum), 72'd0);
    rst = 1'b0;
    waitCycles(2);

    // Single kernel at full rate
    clearLog();
    applyStimulus(7'd1);
    checkOutput("single_busy", 72'(busy), 72'd1);
    sendStream(9, 8'h01, 1'b0);
    checkOutput("single_wr_en", 72'(wr_en), 72'd1);
    checkOutput("single_wr_index", 72'(wr_index), 72'd0);
    checkOutput("single_wr_data", wr_data, 72'h090807060504030201);
    checkOutput("single_ready_low", 72'(in_ready), 72'd0);
    checkOutput("single_no_early_done", 72'(done), 72'd0);
    waitCycles(1);
    checkOutput("single_done", 72'(done), 72'd1);
    checkOutput("single_busy_low", 72'(busy), 72'd0);
    checkOutput("single_wr_en_pulse", 72'(wr_en), 72'd0);
    waitCycles(1);
    checkOutput("single_done_pulse", 72'(done), 72'd0);
    checkOutput("single_hold_data", wr_data, 72'h090807060504030201);
    checkOutput("single_handshakes", 72'(hs_cnt - hs_base), 72'd9);
    checkWrites(1, 8'h01);

    // Full buffer with random valid gaps
    clearLog();
    applyStimulus(7'd21);
    sendStream(189, 8'h00, 1'b1);
    waitCycles(3);
    checkWrites(21, 8'h00);
    checkOutput("full_done_once", 72'(done_cnt - done_base), 72'd1);
    checkOutput("full_handshakes", 72'(hs_cnt - hs_base), 72'd189);
`ifdef WEIGHT_CHECKSUM_EN
    checkOutput("full_checksum", 72'(checksum), 72'(sum_model));
`else
    checkOutput("full_checksum", 72'(checksum), 72'd0);
`endif

    // Clamp: request beyond buffer depth, keep offering bytes afterwards
    clearLog();
    applyStimulus(7'd30);
    sendStream(189, 8'h00, 1'b0);
    checkOutput("clamp_ready_low", 72'(in_ready), 72'd0);
    in_valid = 1'b1;
    in_data = 8'hEE;
    waitCycles(4);
    in_valid = 1'b0;
    checkWrites(21, 8'h00);
    checkOutput("clamp_handshakes", 72'(hs_cnt - hs_base), 72'd189);
    checkOutput("clamp_done", 72'(done_cnt - done_base), 72'd1);

    // Zero count
    clearLog();
    applyStimulus(7'd0);
    checkOutput("zero_done", 72'(done), 72'd1);
    checkOutput("zero_busy", 72'(busy), 72'd0);
    waitCycles(1);
    checkOutput("zero_done_pulse", 72'(done), 72'd0);
    waitCycles(2);
    checkWrites(0, 8'h00);
    checkOutput("zero_ready_never", 72'(ready_cnt - ready_base), 72'd0);
    checkOutput("zero_done_once", 72'(done_cnt - done_base), 72'd1);

    // Abort on the 13th byte (kernel 1, byte 4)
    clearLog();
    applyStimulus(7'd3);
    sendStream(12, 8'h40, 1'b0);
    in_valid = 1'b1;
    in_data = 8'h4C;
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    in_valid = 1'b0;
    checkOutput("abort_busy", 72'(busy), 72'd0);
    checkOutput("abort_ready", 72'(in_ready), 72'd0);
    waitCycles(3);
    checkWrites(1, 8'h40);
    checkOutput("abort_no_done", 72'(done_cnt - done_base), 72'd0);
    clearLog();
    applyStimulus(7'd1);
    sendStream(9, 8'hA0, 1'b0);
    waitCycles(3);
    checkWrites(1, 8'hA0);
    checkOutput("abort_recover_done", 72'(done_cnt - done_base), 72'd1);

    // Asynchronous reset in the middle of a load
    clearLog();
    applyStimulus(7'd2);
    sendStream(5, 8'h10, 1'b0);
    checkOutput("midrst_busy_before", 72'(busy), 72'd1);
    #2 rst = 1'b1;
    #1;
    checkOutput("midrst_busy", 72'(busy), 72'd0);
    checkOutput("midrst_ready", 72'(in_ready), 72'd0);
    checkOutput("midrst_wr_data", wr_data, 72'd0);
    checkOutput("midrst_wr_index", 72'(wr_index), 72'd0);
    checkOutput("midrst_done", 72'(done), 72'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    waitCycles(1);
    checkOutput("midrst_no_done", 72'(done_cnt - done_base), 72'd0);
    clearLog();
    applyStimulus(7'd2);
    sendStream(18, 8'h10, 1'b0);
    waitCycles(3);
    checkWrites(2, 8'h10);
    checkOutput("midrst_done_after", 72'(done_cnt - done_base), 72'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
